// File: rtl/seq_mult_arbiter.sv
// seq_mult_arbiter: shares one sequential multiplier between NUM_REQ requesters.
// Round-robin arbitration picks one request. The block then sequences the
// multiplier through load/run and returns the tagged product on a valid/ready
// response channel.
//
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   req_valid/ready - per-requester handshake (ready is one-hot or zero)
//   req_a, req_b    - flattened operands, requester i at [i*BIT_LEN +: BIT_LEN]
//   resp_valid/ready, resp_id, resp_product - response channel
//   busy            - high whenever not idle
//   mul_load, mul_enable, mul_factor1/2 - multiplier controls and operands
//   mul_product     - multiplier result
module seq_mult_arbiter #(
    parameter int unsigned BIT_LEN     = 4,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = BIT_LEN,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*BIT_LEN-1:0] req_a,
    input  logic [NUM_REQ*BIT_LEN-1:0] req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [2*BIT_LEN-1:0]       resp_product,
    output logic                       busy,
    output logic                       mul_load,
    output logic                       mul_enable,
    output logic [BIT_LEN-1:0]         mul_factor1,
    output logic [BIT_LEN-1:0]         mul_factor2,
    input  logic [2*BIT_LEN-1:0]       mul_product
);

    localparam int unsigned PROD_W = 2 * BIT_LEN;
    localparam int unsigned CNT_W  = $clog2(MUL_LATENCY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_next;
    logic [CNT_W-1:0]   cnt_q, cnt_next;
    logic [BIT_LEN-1:0] op_a_q, op_a_next;
    logic [BIT_LEN-1:0] op_b_q, op_b_next;
    logic [ID_W-1:0]    id_q, id_next;
    logic [ID_W-1:0]    last_q, last_next;
    logic [PROD_W-1:0]  prod_q, prod_next;

    logic               mul_load_q, mul_enable_q, resp_valid_q, busy_q;

    logic [ID_W-1:0]    grant;
    logic               grant_vld;

    // Round-robin search starting just above the last served requester.
    // Walking k downwards lets the closest candidate overwrite farther ones.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = (32'(last_q) + k) % NUM_REQ;
            if (req_valid[ID_W'(idx)]) begin
                grant     = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (reset && (state_q == S_IDLE) && grant_vld) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        op_a_next  = op_a_q;
        op_b_next  = op_b_q;
        id_next    = id_q;
        last_next  = last_q;
        prod_next  = prod_q;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    op_a_next  = req_a[32'(grant) * BIT_LEN +: BIT_LEN];
                    op_b_next  = req_b[32'(grant) * BIT_LEN +: BIT_LEN];
                    id_next    = grant;
                    last_next  = grant;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_next   = CNT_W'(MUL_LATENCY);
                state_next = S_RUN;
            end
            S_RUN: begin
                cnt_next = cnt_q - CNT_W'(1);
                // The final enable cycle: multiplier result is settled.
                if (cnt_q == CNT_W'(1)) begin
                    prod_next  = mul_product;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; control outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            prod_q       <= '0;
            mul_load_q   <= 1'b0;
            mul_enable_q <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_next;
            cnt_q        <= cnt_next;
            op_a_q       <= op_a_next;
            op_b_q       <= op_b_next;
            id_q         <= id_next;
            last_q       <= last_next;
            prod_q       <= prod_next;
            mul_load_q   <= (state_next == S_LOAD);
            mul_enable_q <= (state_next == S_LOAD) || (state_next == S_RUN);
            resp_valid_q <= (state_next == S_DONE);
            busy_q       <= (state_next != S_IDLE);
        end
    end

    assign mul_load     = mul_load_q;
    assign mul_enable   = mul_enable_q;
    assign resp_valid   = resp_valid_q;
    assign busy         = busy_q;
    assign mul_factor1  = op_a_q;
    assign mul_factor2  = op_b_q;
    assign resp_id      = id_q;
    assign resp_product = prod_q;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Self-checking bench for seq_mult_arbiter: a transaction-timing model plus
// directed scenarios with hand-computed literal expectations.
module tb_seq_mult_arbiter;

    localparam int BL  = 4;
    localparam int N   = 4;
    localparam int L   = BL;
    localparam int IDW = 2;
    localparam int PW  = 2 * BL;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*BL-1:0] req_a;
    logic [N*BL-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [IDW-1:0]  resp_id;
    logic [PW-1:0]   resp_product;
    logic            busy;
    logic            mul_load;
    logic            mul_enable;
    logic [BL-1:0]   mul_factor1;
    logic [BL-1:0]   mul_factor2;
    logic [PW-1:0]   mul_product;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_mult_arbiter #(.BIT_LEN(BL), .NUM_REQ(N), .MUL_LATENCY(L), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_product(resp_product),
        .busy(busy),
        .mul_load(mul_load), .mul_enable(mul_enable),
        .mul_factor1(mul_factor1), .mul_factor2(mul_factor2),
        .mul_product(mul_product)
    );

    // Multiplier stand-in: garbage right after load, correct after the first enable.
    always @(posedge clk) begin
        if (reset !== 1'b1)       mul_product <= '0;
        else if (mul_load)        mul_product <= 8'hA5;
        else if (mul_enable)      mul_product <= PW'(int'(mul_factor1) * int'(mul_factor2));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int grant_of(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (((v >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    // Model: phase -1 is idle, otherwise cycles since accept (1 = load cycle).
    int            m_phase = -1;
    int            m_last  = N - 1;
    logic [BL-1:0] m_a = '0, m_b = '0;
    logic [PW-1:0] m_prod = '0;
    int            m_id = 0;

    always @(posedge clk) begin
        int g;
        if (reset !== 1'b1) begin
            m_phase = -1; m_last = N - 1; m_a = '0; m_b = '0; m_prod = '0; m_id = 0;
        end else if (m_phase < 0) begin
            g = grant_of(req_valid, m_last);
            if (g >= 0) begin
                m_a = req_a[g*BL +: BL];
                m_b = req_b[g*BL +: BL];
                m_id = g; m_last = g; m_phase = 1;
            end
        end else if (m_phase < 2 + L) begin
            if (m_phase == 1 + L) m_prod = PW'(int'(m_a) * int'(m_b));
            m_phase++;
        end else if (resp_ready === 1'b1) begin
            m_phase = -1;
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        if (chk_en) begin
            g = grant_of(req_valid, m_last);
            exp_rdy = (reset === 1'b1 && m_phase < 0 && g >= 0) ? (N'(1) << g) : '0;
            check("m_req_ready", 32'(req_ready), 32'(exp_rdy));
            check("m_mul_load", 32'(mul_load), 32'(m_phase == 1));
            check("m_mul_enable", 32'(mul_enable), 32'(m_phase >= 1 && m_phase <= 1 + L));
            check("m_resp_valid", 32'(resp_valid), 32'(m_phase >= 2 + L));
            check("m_busy", 32'(busy), 32'(m_phase >= 0));
            check("m_resp_product", 32'(resp_product), 32'(m_prod));
            check("m_resp_id", 32'(resp_id), 32'(m_id));
            check("m_factor1", 32'(mul_factor1), 32'(m_a));
            check("m_factor2", 32'(mul_factor2), 32'(m_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("resp_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int exp_id[5]   = '{0, 1, 2, 3, 0};
        int exp_prod[5] = '{3, 6, 225, 0, 3};

        // Reset with every requester valid.
        reset = 1'b0; resp_ready = 1'b1;
        req_a = {4'd0, 4'd15, 4'd2, 4'd1};
        req_b = {4'd7, 4'd15, 4'd3, 4'd3};
        req_valid = 4'hF;
        tick();
        chk_en = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_product", 32'(resp_product), 32'(0));
        check("rst_id", 32'(resp_id), 32'(0));
        check("rst_load_en", 32'({mul_load, mul_enable}), 32'(0));
        check("rst_factors", 32'({mul_factor1, mul_factor2}), 32'(0));
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("first_grant", 32'(req_ready), 32'(4'b0001));

        // Round-robin with everyone continuously valid.
        for (int i = 0; i < 5; i++) begin
            wait_resp(ok);
            if (ok) begin
                check("rr_id", 32'(resp_id), 32'(exp_id[i]));
                check("rr_product", 32'(resp_product), 32'(exp_prod[i]));
            end
            tick();
        end
        req_valid = '0;

        // Single request from requester 2: 2 x 1.
        tick();
        req_a[11:8] = 4'd2; req_b[11:8] = 4'd1; req_valid = 4'b0100;
        @(negedge clk);
        check("single_t0_ready", 32'(req_ready), 32'(4'b0100));
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_t1_load", 32'({mul_load, mul_enable, busy}), 32'(3'b111));
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check("single_run", 32'({mul_load, mul_enable, resp_valid}), 32'(3'b010));
        end
        @(negedge clk);
        check("single_t6_valid", 32'(resp_valid), 32'(1));
        check("single_t6_product", 32'(resp_product), 32'(8'h02));
        check("single_t6_id", 32'(resp_id), 32'(2));
        @(negedge clk);
        check("single_t7_busy", 32'({busy, resp_valid}), 32'(0));

        // Backpressure: r0 (3x5) served first, r1 (4x4) waits.
        tick();
        resp_ready = 1'b0;
        req_a[3:0] = 4'd3; req_b[3:0] = 4'd5;
        req_a[7:4] = 4'd4; req_b[7:4] = 4'd4;
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0010;
        wait_resp(ok);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            check("bp_product", 32'(resp_product), 32'(15));
            check("bp_id", 32'(resp_id), 32'(0));
            check("bp_hold", 32'({resp_valid, mul_enable, req_ready}), 32'(6'b100000));
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(resp_valid), 32'(1));
        @(negedge clk);
        check("bp_idle_busy", 32'(busy), 32'(0));
        check("bp_idle_ready", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = '0;
        wait_resp(ok);
        if (ok) check("bp_r1_product", 32'({resp_id, resp_product}), 32'({2'd1, 8'd16}));
        tick();

        // Reset during RUN of requester 3, then r1 computes 15x15.
        req_a[15:12] = 4'd5; req_b[15:12] = 4'd6; req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 32'({busy, mul_enable, resp_valid, mul_load}), 32'(0));
        tick();
        req_a[7:4] = 4'd15; req_b[7:4] = 4'd15; req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_resp(ok);
        if (ok) check("mid_rst_result", 32'({resp_id, resp_product}), 32'({2'd1, 8'd225}));
        tick();

        // Late arrival: r1 rises during r3's RUN and wins the next grant.
        req_a[15:12] = 4'd2; req_b[15:12] = 4'd2;
        req_a[7:4] = 4'd3; req_b[7:4] = 4'd7;
        req_valid = 4'b1000;
        tick();
        tick();
        req_valid = 4'b1010;
        @(negedge clk);
        check("late_not_ready", 32'(req_ready), 32'(0));
        wait_resp(ok);
        if (ok) check("late_r3_result", 32'({resp_id, resp_product}), 32'({2'd3, 8'd4}));
        @(negedge clk);
        check("late_priority", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = 4'b1000;
        wait_resp(ok);
        if (ok) check("late_r1_result", 32'({resp_id, resp_product}), 32'({2'd1, 8'd21}));
        tick();
        @(negedge clk);
        check("late_r3_again", 32'(req_ready), 32'(4'b1000));
        tick();
        req_valid = '0;
        wait_resp(ok);
        if (ok) check("late_r3_final", 32'({resp_id, resp_product}), 32'({2'd3, 8'd4}));
        tick();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
